alu_seq_ctrl: RTL and testbench

- Command sequencer for the shared 8-bit combinational ALU (ops add, sub, and, or, not, xor, shl, shr; flags z, n, c, v).
- Accepts one command at a time over a valid/ready handshake and drives the ALU operand and select inputs.
- Single ALU ops complete in one execute cycle. An 8x8 unsigned multiply runs as eight ALU add passes (shift-add).
- Results are returned over a valid/ready response channel. The ALU instance sits beside this block in the parent.

---
 rtl/alu_ctrl_pkg.sv | 35 +++
 rtl/alu_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU command sequencer: opcode values, the
// sequencer state encoding and bit positions inside the 4-bit flag word.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    localparam int DATA_W = 8;

    // 0-7 are passed straight through to the ALU select, 8 is the
    // sequenced multiply, anything above 8 is rejected.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Flag word layout {z,n,c,v}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Command sequencer in front of a shared 8-bit combinational ALU. One command
// is accepted at a time; single ALU ops take one execute cycle, an 8x8
// unsigned multiply is performed as eight shift-add passes through the ALU.
// The result is held on a valid/ready response channel until taken.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_op[3:0], cmd_a, cmd_b      opcode and operands
//   rsp_valid/rsp_ready            response handshake
//   rsp_data[15:0], rsp_flags[3:0] result and {z,n,c,v}
//   rsp_err                        illegal opcode indication
//   busy                           high whenever not IDLE
//   alu_a, alu_b, alu_s            drive to the external ALU
//   alu_out, alu_z/n/c/v           result and flags back from the ALU
// ---------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_ITER = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_s,
    input  logic [7:0]  alu_out,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v
);

    state_t      state_q, state_d;
    // Only the ALU select is kept; whether the command was a single op,
    // a multiply or illegal is already encoded by the state it moved to.
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  p_q, p_d;
    logic [7:0]  q_q, q_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_err_q, rsp_err_d;

    logic        cy;
    logic [7:0]  p_next;
    logic [7:0]  q_next;
    logic        last_iter;

    assign last_iter = (cnt_q == 3'(MUL_ITER - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op < OP_MUL) begin
                        state_d = EXEC;
                    end else if (cmd_op == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            EXEC:    state_d = RESP;
            MUL:     if (last_iter) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == RESP);
        rsp_data  = rsp_data_q;
        rsp_flags = rsp_flags_q;
        rsp_err   = rsp_err_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_s     = '0;
        unique case (state_q)
            EXEC: begin
                alu_a = a_q;
                alu_b = b_q;
                alu_s = op_q;
            end
            MUL: begin
                alu_a = p_q;
                alu_b = q_q[0] ? a_q : 8'h00;
                alu_s = OP_ADD[2:0];
            end
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;

        // The ALU carry flag is not trusted for the partial-product add; a
        // wrapped 8-bit sum is always smaller than the addend P.
        cy     = (alu_out < p_q);
        p_next = {cy, alu_out[7:1]};
        q_next = {alu_out[0], q_q[7:1]};

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op[2:0];
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    p_d   = '0;
                    q_d   = cmd_b;
                    cnt_d = '0;
                    if (cmd_op > OP_MUL) begin
                        rsp_data_d  = '0;
                        rsp_flags_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            EXEC: begin
                rsp_data_d            = {8'h00, alu_out};
                rsp_flags_d[FLAG_Z]   = alu_z;
                rsp_flags_d[FLAG_N]   = alu_n;
                rsp_flags_d[FLAG_C]   = alu_c;
                rsp_flags_d[FLAG_V]   = alu_v;
                rsp_err_d             = 1'b0;
            end
            MUL: begin
                p_d   = p_next;
                q_d   = q_next;
                cnt_d = cnt_q + 3'd1;
                if (last_iter) begin
                    rsp_data_d          = {p_next, q_next};
                    rsp_flags_d[FLAG_Z] = ({p_next, q_next} == 16'h0000);
                    rsp_flags_d[FLAG_N] = p_next[7];
                    rsp_flags_d[FLAG_C] = 1'b0;
                    rsp_flags_d[FLAG_V] = 1'b0;
                    rsp_err_d           = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Bench for the ALU command sequencer. The bench supplies the combinational
// ALU the sequencer drives, then applies a table of directed commands, a few
// hand-written multi-cycle sequences and a batch of random commands scored
// against a behavioural model (plain arithmetic for the result and latency).
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_s;
    logic [7:0]  alu_out;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic [11:0] alu_res;

    int total = 0;
    int bad   = 0;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_out   (alu_out),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .alu_c     (alu_c),
        .alu_v     (alu_v)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The shared ALU: returns {z,n,c,v,result}
    function automatic logic [11:0] alu_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (s)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~a;
            3'd5: r = a ^ b;
            3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
            default: begin r = {1'b0, a[7:1]}; c = a[0]; end
        endcase
        return {(r == 8'h00), r[7], c, v, r};
    endfunction

    assign alu_res = alu_fn(alu_s, alu_a, alu_b);
    assign alu_out = alu_res[7:0];
    assign alu_z   = alu_res[11];
    assign alu_n   = alu_res[10];
    assign alu_c   = alu_res[9];
    assign alu_v   = alu_res[8];

    // Behavioural reference: result, flags, error and latency of one command
    function automatic void ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                      output logic [15:0] d, output logic [3:0] f,
                                      output logic e, output int lat);
        logic [11:0] r;
        int unsigned prod;
        if (op < 4'd8) begin
            r = alu_fn(op[2:0], a, b);
            d = {8'h00, r[7:0]}; f = r[11:8]; e = 1'b0; lat = 2;
        end else if (op == 4'd8) begin
            prod = int'(a) * int'(b);
            d = prod[15:0]; f = {(prod == 0), prod[15], 2'b00}; e = 1'b0; lat = 9;
        end else begin
            d = '0; f = '0; e = 1'b1; lat = 1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command, wait for its response (bounded), optionally stall
    // the response for 'hold' cycles, then take it.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int hold,
                          output logic [15:0] d, output logic [3:0] f, output logic e,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        busy_ok = 1'b1;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        repeat (hold) @(negedge clk);
        d = rsp_data; f = rsp_flags; e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input int hold, input logic [15:0] ed, input logic [3:0] ef,
                             input logic ee, input int elat);
        logic [15:0] d;
        logic [3:0]  f;
        logic        e;
        int          lat;
        bit          busy_ok;
        do_cmd(op, a, b, hold, d, f, e, lat, busy_ok);
        chk({name, " data"}, 32'(d), 32'(ed));
        chk({name, " flags"}, 32'(f), 32'(ef));
        chk({name, " err"}, 32'(e), 32'(ee));
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " busy"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        chk({name, " rsp_valid after take"}, 32'(rsp_valid), 32'd0);
        chk({name, " cmd_ready after take"}, 32'(cmd_ready), 32'd1);
        chk({name, " data held in idle"}, 32'(rsp_data), 32'(ed));
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_data;
        logic [3:0]  exp_flags;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [15:0] ed;
        logic [3:0]  ef;
        logic        ee;
        int          elat;
        int          n_valid;

        // {name, op, a, b, data, flags{z,n,c,v}, err, latency}
        vecs.push_back('{"add 5+3",     4'd0, 8'h05, 8'h03, 16'h0008, 4'b0000, 1'b0, 2});
        vecs.push_back('{"add 7f+1",    4'd0, 8'h7F, 8'h01, 16'h0080, 4'b0101, 1'b0, 2});
        vecs.push_back('{"add ff+1",    4'd0, 8'hFF, 8'h01, 16'h0000, 4'b1010, 1'b0, 2});
        vecs.push_back('{"sub 10-10",   4'd1, 8'h10, 8'h10, 16'h0000, 4'b1000, 1'b0, 2});
        vecs.push_back('{"sub 3-5",     4'd1, 8'h03, 8'h05, 16'h00FE, 4'b0110, 1'b0, 2});
        vecs.push_back('{"and",         4'd2, 8'hF0, 8'h3C, 16'h0030, 4'b0000, 1'b0, 2});
        vecs.push_back('{"or",          4'd3, 8'h80, 8'h01, 16'h0081, 4'b0100, 1'b0, 2});
        vecs.push_back('{"not",         4'd4, 8'h00, 8'h5A, 16'h00FF, 4'b0100, 1'b0, 2});
        vecs.push_back('{"xor",         4'd5, 8'hAA, 8'hFF, 16'h0055, 4'b0000, 1'b0, 2});
        vecs.push_back('{"shl",         4'd6, 8'h81, 8'h00, 16'h0002, 4'b0010, 1'b0, 2});
        vecs.push_back('{"shr",         4'd7, 8'h01, 8'h00, 16'h0000, 4'b1010, 1'b0, 2});
        vecs.push_back('{"mul ff*ff",   4'd8, 8'hFF, 8'hFF, 16'hFE01, 4'b0100, 1'b0, 9});
        vecs.push_back('{"mul 37*00",   4'd8, 8'h37, 8'h00, 16'h0000, 4'b1000, 1'b0, 9});
        vecs.push_back('{"mul 0d*0b",   4'd8, 8'h0D, 8'h0B, 16'h008F, 4'b0000, 1'b0, 9});
        vecs.push_back('{"mul 80*02",   4'd8, 8'h80, 8'h02, 16'h0100, 4'b0000, 1'b0, 9});
        vecs.push_back('{"illegal c",   4'hC, 8'h12, 8'h34, 16'h0000, 4'b0000, 1'b1, 1});
        vecs.push_back('{"illegal f",   4'hF, 8'hFF, 8'hFF, 16'h0000, 4'b0000, 1'b1, 1});

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset rsp_flags", 32'(rsp_flags), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset alu drive", 32'({alu_a, alu_b, alu_s}), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 0,
                      vecs[i].exp_data, vecs[i].exp_flags, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Backpressure: response held 5 cycles, a command pulse is ignored
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h21; cmd_b = 8'h12;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n_valid = 0;
        @(negedge clk);
        while (!rsp_valid && n_valid < 40) begin
            @(negedge clk);
            n_valid++;
        end
        chk("bp response arrives", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp rsp_data", 32'(rsp_data), 32'h0033);
            chk("bp rsp_flags", 32'(rsp_flags), 32'd0);
            chk("bp cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp busy", 32'(busy), 32'd1);
            chk("bp alu drive", 32'({alu_a, alu_b, alu_s}), 32'd0);
            cmd_valid = (i == 2);
            cmd_op = 4'd8; cmd_a = 8'h77; cmd_b = 8'h66;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp rsp_valid dropped", 32'(rsp_valid), 32'd0);
        chk("bp pulse ignored", 32'({busy, cmd_ready}), 32'b01);

        // Reset during the fifth multiply iteration
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 8'hFF; cmd_b = 8'hFF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-mul busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort rsp_data", 32'(rsp_data), 32'd0);
        n_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) n_valid++;
        end
        chk("abort response dropped", 32'(n_valid), 32'd0);
        run_check("add after abort", 4'd0, 8'h40, 8'h02, 0, 16'h0042, 4'b0000, 1'b0, 2);

        // Random commands against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            logic [7:0] a;
            logic [7:0] b;
            op = 4'($urandom_range(0, 15));
            if (i % 3 == 0) op = 4'd8;
            a  = 8'($urandom);
            b  = 8'($urandom);
            ref_model(op, a, b, ed, ef, ee, elat);
            run_check("random", op, a, b, int'($urandom_range(0, 3)), ed, ef, ee, elat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
